// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline stages.
//  - ALU operation and writeback source encodings
//  - architectural x0 register index
//  - id_ex_t: the bundle carried from ID to EX, and BUBBLE, its all-zero (NOP) value
package riscv_pipe_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              reg_wen;
    logic              mem_rw;
    logic              mem_rd;
    logic [3:0]        alu_sel;
    logic              a_sel;
    logic              b_sel;
    logic [1:0]        wb_sel;
  } id_ex_t;

  // A bubble carries no register indices, so it can never match in forwarding.
  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//  A load sitting in EX whose destination is read by the valid, unflushed
//  instruction in ID cannot be forwarded in time, so ID must wait one cycle.
// Ports:
//  ex_valid, ex_mem_rd, ex_rd          in  : the instruction currently in EX
//  id_valid, id_rs1/rs2, id_rs*_used   in  : the instruction currently in ID
//  ex_flush                            in  : ID is being squashed anyway
//  hazard                              out : stall request (combinational)
module load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       ex_flush,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_used,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_used,
  output logic       hazard
);

  logic load_in_ex;
  logic src_match;

  // Writes to x0 are discarded, so a load to x0 never creates a dependency.
  assign load_in_ex = ex_valid & ex_mem_rd & (ex_rd != REG_X0);
  assign src_match  = (id_rs1_used & (id_rs1 == ex_rd)) |
                      (id_rs2_used & (id_rs2 == ex_rd));
  assign hazard     = load_in_ex & src_match & id_valid & ~ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
//  Captures the decoded ID instruction each cycle and presents it to EX.
//  Priority per edge: rst > mem_stall (hold) > ex_flush (bubble)
//  > load-use hazard (bubble + count) > normal load.
// Ports:
//  clk, rst (sync, active-high), mem_stall, ex_flush  : control
//  id_*                                               : decoded ID instruction
//  ex_*                                               : registered copies, plus ex_valid
//  hazard_stall                                       : combinational stall request
//  stall_cnt                                          : saturating load-use bubble count
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN  = DATA_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_stall,
  input  logic             ex_flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_RegWEn,
  input  logic             id_MemRW,
  input  logic             id_MemRd,
  input  logic [3:0]       id_ALUSel,
  input  logic             id_ASel,
  input  logic             id_BSel,
  input  logic [1:0]       id_WBSel,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic             ex_rs1_used,
  output logic             ex_rs2_used,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic             ex_RegWEn,
  output logic             ex_MemRW,
  output logic             ex_MemRd,
  output logic [3:0]       ex_ALUSel,
  output logic             ex_ASel,
  output logic             ex_BSel,
  output logic [1:0]       ex_WBSel,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  id_ex_t           id_bundle;
  id_ex_t           ex_q;
  id_ex_t           ex_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hazard;

  load_use_detect u_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_rd   (ex_q.mem_rd),
    .ex_rd       (ex_q.rd),
    .id_valid    (id_valid),
    .ex_flush    (ex_flush),
    .id_rs1      (id_rs1),
    .id_rs1_used (id_rs1_used),
    .id_rs2      (id_rs2),
    .id_rs2_used (id_rs2_used),
    .hazard      (hazard)
  );

  // Gather the ID-side ports into one bundle.
  always_comb begin
    id_bundle          = BUBBLE;
    id_bundle.valid    = id_valid;
    id_bundle.pc       = id_pc;
    id_bundle.rs1      = id_rs1;
    id_bundle.rs2      = id_rs2;
    id_bundle.rs1_used = id_rs1_used;
    id_bundle.rs2_used = id_rs2_used;
    id_bundle.rd       = id_rd;
    id_bundle.rs1_data = id_rs1_data;
    id_bundle.rs2_data = id_rs2_data;
    id_bundle.imm      = id_imm;
    id_bundle.reg_wen  = id_RegWEn;
    id_bundle.mem_rw   = id_MemRW;
    id_bundle.mem_rd   = id_MemRd;
    id_bundle.alu_sel  = id_ALUSel;
    id_bundle.a_sel    = id_ASel;
    id_bundle.b_sel    = id_BSel;
    id_bundle.wb_sel   = id_WBSel;
  end

  // Priority mux for the next EX contents; hazard already excludes flush.
  always_comb begin
    ex_nxt = ex_q;
    if (mem_stall) begin
      ex_nxt = ex_q;
    end else if (ex_flush || hazard) begin
      ex_nxt = BUBBLE;
    end else begin
      ex_nxt = id_bundle;
    end
  end

  // Bubble counter: advances only on bubbles actually inserted, saturating.
  always_comb begin
    cnt_nxt = cnt_q;
    if (!mem_stall && hazard && (cnt_q != CNT_MAX)) begin
      cnt_nxt = cnt_q + CNT_ONE;
    end else begin
      cnt_nxt = cnt_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rs1_used  = ex_q.rs1_used;
  assign ex_rs2_used  = ex_q.rs2_used;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_RegWEn    = ex_q.reg_wen;
  assign ex_MemRW     = ex_q.mem_rw;
  assign ex_MemRd     = ex_q.mem_rd;
  assign ex_ALUSel    = ex_q.alu_sel;
  assign ex_ASel      = ex_q.a_sel;
  assign ex_BSel      = ex_q.b_sel;
  assign ex_WBSel     = ex_q.wb_sel;
  assign hazard_stall = hazard;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard testbench for id_ex_stage.
//  The driver pushes the hand-computed EX contents expected after each edge;
//  a separate monitor pops and compares one entry per clock edge.
//  The counter is built 2 bits wide so saturation is reached with a few hazards.
module tb_id_ex_stage;
  import riscv_pipe_pkg::*;

  typedef struct {
    id_ex_t     ex;
    logic       full;
    logic [1:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, mem_stall, ex_flush;
  logic        id_valid, id_rs1_used, id_rs2_used;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_RegWEn, id_MemRW, id_MemRd, id_ASel, id_BSel;
  logic [3:0]  id_ALUSel;
  logic [1:0]  id_WBSel;
  logic        ex_valid, ex_rs1_used, ex_rs2_used;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_RegWEn, ex_MemRW, ex_MemRd, ex_ASel, ex_BSel;
  logic [3:0]  ex_ALUSel;
  logic [1:0]  ex_WBSel;
  logic        hazard_stall;
  logic [1:0]  stall_cnt;

  int     errors = 0;
  int     checks = 0;
  exp_t   sb_q[$];
  id_ex_t cur;

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_RegWEn(id_RegWEn), .id_MemRW(id_MemRW), .id_MemRd(id_MemRd),
    .id_ALUSel(id_ALUSel), .id_ASel(id_ASel), .id_BSel(id_BSel), .id_WBSel(id_WBSel),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_RegWEn(ex_RegWEn), .ex_MemRW(ex_MemRW), .ex_MemRd(ex_MemRd),
    .ex_ALUSel(ex_ALUSel), .ex_ASel(ex_ASel), .ex_BSel(ex_BSel), .ex_WBSel(ex_WBSel),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Build a decoded instruction; payload fields are derived from the PC so each is distinct.
  function automatic id_ex_t mk(input logic [31:0] pc, input logic ld, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
    id_ex_t b;
    b          = BUBBLE;
    b.valid    = 1'b1;
    b.pc       = pc;
    b.rs1      = rs1;
    b.rs2      = rs2;
    b.rs1_used = u1;
    b.rs2_used = u2;
    b.rd       = rd;
    b.rs1_data = pc ^ 32'h1111_0000;
    b.rs2_data = pc ^ 32'h2222_0000;
    b.imm      = pc + 32'h0000_0040;
    b.reg_wen  = 1'b1;
    b.mem_rw   = pc[3] & ~ld;
    b.mem_rd   = ld;
    b.alu_sel  = ld ? 4'(ALU_ADD) : 4'(ALU_XOR);
    b.a_sel    = pc[4];
    b.b_sel    = ld;
    b.wb_sel   = ld ? 2'(WB_MEM) : 2'(WB_ALU);
    return b;
  endfunction

  task automatic apply(input id_ex_t b);
    id_valid = b.valid;       id_pc = b.pc;
    id_rs1 = b.rs1;           id_rs2 = b.rs2;
    id_rs1_used = b.rs1_used; id_rs2_used = b.rs2_used;
    id_rd = b.rd;             id_rs1_data = b.rs1_data;
    id_rs2_data = b.rs2_data; id_imm = b.imm;
    id_RegWEn = b.reg_wen;    id_MemRW = b.mem_rw;
    id_MemRd = b.mem_rd;      id_ALUSel = b.alu_sel;
    id_ASel = b.a_sel;        id_BSel = b.b_sel;
    id_WBSel = b.wb_sel;
  endtask

  // One clock: drive `cur` plus control, check hazard_stall, queue the post-edge expectation.
  task automatic tick(input logic fl, input logic ms, input logic r, input logic exp_haz,
                      input id_ex_t exp_ex, input logic full, input logic [1:0] exp_cnt);
    exp_t e;
    @(negedge clk);
    apply(cur);
    ex_flush = fl; mem_stall = ms; rst = r;
    #1;
    checks++;
    if (hazard_stall !== exp_haz) begin
      errors++;
      $display("FAIL hazard_stall @%0t: got %b want %b", $time, hazard_stall, exp_haz);
    end
    e.ex = exp_ex; e.full = full; e.cnt = exp_cnt;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: after every edge, compare EX outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t   e;
    id_ex_t act;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = BUBBLE;
      act.valid = ex_valid;       act.pc = ex_pc;
      act.rs1 = ex_rs1;           act.rs2 = ex_rs2;
      act.rs1_used = ex_rs1_used; act.rs2_used = ex_rs2_used;
      act.rd = ex_rd;             act.rs1_data = ex_rs1_data;
      act.rs2_data = ex_rs2_data; act.imm = ex_imm;
      act.reg_wen = ex_RegWEn;    act.mem_rw = ex_MemRW;
      act.mem_rd = ex_MemRd;      act.alu_sel = ex_ALUSel;
      act.a_sel = ex_ASel;        act.b_sel = ex_BSel;
      act.wb_sel = ex_WBSel;
      checks++;
      if (e.full) begin
        if (act !== e.ex) begin
          errors++;
          $display("FAIL ex_bundle @%0t: got %h want %h", $time, act, e.ex);
        end
      end else if (ex_valid !== e.ex.valid) begin
        errors++;
        $display("FAIL ex_valid @%0t: got %b want %b", $time, ex_valid, e.ex.valid);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    id_ex_t ld, dep, inv;
    cur = BUBBLE;
    apply(cur);
    rst = 1'b1; mem_stall = 1'b0; ex_flush = 1'b0;

    // T1: reset for two cycles
    tick(1'b0, 1'b0, 1'b1, 1'b0, BUBBLE, 1'b1, 2'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, BUBBLE, 1'b1, 2'd0);

    // T2: lw x5 ; add x6,x5,x1 -> one bubble, then the add
    ld  = mk(32'd100, 1'b1, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd104, 1'b0, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,     1'b1, 2'd0);
    cur = dep; tick(1'b0, 1'b0, 1'b0, 1'b1, BUBBLE, 1'b1, 2'd1);
               tick(1'b0, 1'b0, 1'b0, 1'b0, dep,    1'b1, 2'd1);

    // T3: load to x0, and an unused rs2 that matches -> no stall
    ld  = mk(32'd108, 1'b1, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd112, 1'b0, 5'd6, 5'd0, 1'b1, 5'd1, 1'b1);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,  1'b1, 2'd1);
    cur = dep; tick(1'b0, 1'b0, 1'b0, 1'b0, dep, 1'b1, 2'd1);
    ld  = mk(32'd116, 1'b1, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd120, 1'b0, 5'd7, 5'd1, 1'b1, 5'd5, 1'b0);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,  1'b1, 2'd1);
    cur = dep; tick(1'b0, 1'b0, 1'b0, 1'b0, dep, 1'b1, 2'd1);

    // T4: flush together with a hazard -> bubble, no stall, count unchanged
    ld  = mk(32'd124, 1'b1, 5'd5, 5'd3, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd128, 1'b0, 5'd8, 5'd5, 1'b1, 5'd0, 1'b0);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,     1'b1, 2'd1);
    cur = dep; tick(1'b1, 1'b0, 1'b0, 1'b0, BUBBLE, 1'b1, 2'd1);
               tick(1'b0, 1'b0, 1'b0, 1'b0, dep,    1'b1, 2'd1);

    // T5: mem_stall for 3 cycles during a hazard (dependency through rs2)
    ld  = mk(32'd132, 1'b1, 5'd9, 5'd1, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd136, 1'b0, 5'd10, 5'd0, 1'b0, 5'd9, 1'b1);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld, 1'b1, 2'd1);
    cur = dep;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b1, ld, 1'b1, 2'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, BUBBLE, 1'b1, 2'd2);
    tick(1'b0, 1'b0, 1'b0, 1'b0, dep,    1'b1, 2'd2);

    // id_valid=0 with a matching source -> no stall, ex_valid=0
    ld  = mk(32'd144, 1'b1, 5'd11, 5'd1, 1'b1, 5'd0, 1'b0);
    inv = mk(32'd148, 1'b0, 5'd12, 5'd11, 1'b1, 5'd0, 1'b0);
    inv.valid = 1'b0;
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,     1'b1, 2'd2);
    cur = inv; tick(1'b0, 1'b0, 1'b0, 1'b0, BUBBLE, 1'b0, 2'd2);

    // T6: counter reaches all-ones, then holds there
    ld  = mk(32'd152, 1'b1, 5'd13, 5'd1, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd156, 1'b0, 5'd14, 5'd13, 1'b1, 5'd0, 1'b0);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,     1'b1, 2'd2);
    cur = dep; tick(1'b0, 1'b0, 1'b0, 1'b1, BUBBLE, 1'b1, 2'd3);
               tick(1'b0, 1'b0, 1'b0, 1'b0, dep,    1'b1, 2'd3);
    ld  = mk(32'd160, 1'b1, 5'd15, 5'd1, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd164, 1'b0, 5'd16, 5'd15, 1'b1, 5'd0, 1'b0);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,     1'b1, 2'd3);
    cur = dep; tick(1'b0, 1'b0, 1'b0, 1'b1, BUBBLE, 1'b1, 2'd3);
               tick(1'b0, 1'b0, 1'b0, 1'b0, dep,    1'b1, 2'd3);

    // Reset asserted mid-stall -> clean zero state, then the dependent issues
    ld  = mk(32'd168, 1'b1, 5'd17, 5'd1, 1'b1, 5'd0, 1'b0);
    dep = mk(32'd172, 1'b0, 5'd18, 5'd17, 1'b1, 5'd0, 1'b0);
    cur = ld;  tick(1'b0, 1'b0, 1'b0, 1'b0, ld,     1'b1, 2'd3);
    cur = dep; tick(1'b0, 1'b1, 1'b0, 1'b1, ld,     1'b1, 2'd3);
               tick(1'b0, 1'b1, 1'b1, 1'b1, BUBBLE, 1'b1, 2'd0);
               tick(1'b0, 1'b0, 1'b0, 1'b0, dep,    1'b1, 2'd0);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
